conv_kernel_array: RTL and testbench
====================================

// Module: conv_kernel_array
// PURPOSE
//  Kernel-side compute slice of the accelerator: KernelBuffer (banked weight RAM), KernelBufferDistributor
//  (lane rotate/mask) and a DxD PE ConvolutionalUnit mesh. Buffer rows feed mesh rows; neuron-buffer words feed
//  mesh columns; per-row partial sums chain left->right across columns and leave to the pooling unit.
// PARAMETERS
//  DEPTH 2  log2 of mesh dimension; D = 1<<DEPTH lanes/rows/columns (derived, not overridable)
//  W     16 signed two's-complement data width
//  AB    11 kernel-buffer address width (2^AB words of D*W bits)
//  AL    7  per-PE local kernel-store address width (2^AL words of W bits)
// PORTS
//  CLK          in  1            rising-edge clock
//  RST          in  1            synchronous active-high reset
//  kb_address   in  AB           kernel buffer read/write address
//  kb_io        in  W+DEPTH+2    {we, bcast, lane[DEPTH-1:0], data[W-1:0]} host load port
//  dist_ctrl    in  2*DEPTH      {zcnt[DEPTH-1:0], rot[DEPTH-1:0]}
//  neuron_in    in  W*D          column j data = [W*(j+1)-1 -: W]
//  psum_in      in  W*D          row i chain seed = [W*(i+1)-1 -: W]
//  col_ctrl     in  8*D          column j = [8*(j+1)-1 -: 8]
//  row_ctrl     in  D            bit i: row i kernel-write enable
//  common_ctrl  in  3*DEPTH+2*AL+1  {shift[3*DEPTH-1:0], raddr[AL-1:0], waddr[AL-1:0], out_en}
//  psum_out     out W*D          row i result = [W*(i+1)-1 -: W]
// BEHAVIOUR
//  Kernel buffer: mem[2^AB][D*W]; contents not reset.
//   - we=1: lane `lane` of mem[kb_address] <= data; bcast=1 writes data to all D lanes.
//   - Sync read, 1-cycle latency: kb_q <= mem[kb_address] every cycle, read-before-write on collision.
//   - RST: kb_q <= 0.
//  Distributor (combinational on kb_q):
//   - out lane i = kb_q lane (i+rot) mod D.
//   - Lanes i >= D-zcnt forced 0 (zcnt=0 masks nothing).
//  PE(i,j): kernel store ks[2^AL][W], neuron register nr[W].
//   - col_ctrl[j] bits: [0] nload, [1] kwrite, [2] mac_en, [3] zero, [7:4] reserved (ignored).
//   - nload: nr <= neuron_in lane j.
//   - kwrite & row_ctrl[i]: ks[waddr] <= distributor lane i.
//   - prod = (ks[raddr] * nr), full 2W signed, arithmetic shift right by min(shift, W-1), low W bits kept.
//   - prod forced 0 when zero=1 or mac_en=0.
//   - Chain (combinational through all D columns): c[i][0] = psum_in lane i; c[i][j+1] = c[i][j] + prod(i,j), W-bit wrap.
//   - out_en=1: psum_out lane i <= c[i][D] (registered, 1-cycle latency); out_en=0 holds psum_out.
//   - RST: psum_out <= 0, all nr <= 0; ks not reset.
//  Timing and boundaries:
//   - Buffer-to-PE path: kb_address at edge t, kernel lands in ks at edge t+1 when kwrite asserted that cycle.
//   - ks read-during-write at the same address returns the old value.
//   - RST has priority over every write; in-flight products discarded.
//   - Address wrap is natural modulo 2^AB / 2^AL.
// CONFIGURATION
//  CONV_SATURATE_EN defined:
//   - every chain add saturates to [-2^(W-1), 2^(W-1)-1];
//   - shifted product saturated to W bits instead of truncated.
//  Undefined: W-bit two's-complement wrap everywhere.
// TESTING (D=4, W=16)
//  - Buffer load/read:
//    - write lanes 0..3 of addr 5 = 1,2,3,4; read 5, rot=0 zcnt=0 -> kb_q lanes {1,2,3,4} one cycle after read address.
//    - rot=1 -> lanes {2,3,4,1}; zcnt=2 -> lanes {1,2,0,0}.
//    - bcast write 0x00AA to addr 7 -> all lanes 0x00AA.
//  - Single MAC:
//    - ks(0,0)[0]=3, nr(0,0)=5, only col0 mac_en, psum_in=10, out_en=1 -> psum_out lane0 = 25 next cycle.
//  - Full row chain:
//    - all ks=2, neuron_in lanes {1,2,3,4}, all mac_en, psum_in=0 -> every psum_out lane = 20.
//  - Shift and overflow:
//    - ks=0x4000, nr=0x4000, shift=14 -> prod 0x4000.
//    - psum_in 0x7FFF + 1 -> 0x8000 (wrap) / 0x7FFF with CONV_SATURATE_EN.
//  - Hold/reset:
//    - out_en=0 holds psum_out across input changes.
//    - RST mid-stream -> psum_out=0, nr=0 next edge; ks contents preserved.

Source files
------------

// File: rtl/conv_kernel_array.sv
// -----------------------------------------------------------------------------
// conv_kernel_array
//   Kernel-side compute slice: a banked weight RAM (kernel buffer), a lane
//   rotate/mask distributor and a DxD mesh of multiply-accumulate PEs.
//   Buffer lanes feed mesh rows, neuron words feed mesh columns, and each row
//   chains its partial sum left to right across the columns into a
//   registered output.
//
//   Optional build macro: CONV_SATURATE_EN
//     defined   : shifted products and every chain add saturate to W bits
//     undefined : W-bit two's-complement wrap everywhere
//
// Ports
//   CLK          rising-edge clock
//   RST          synchronous active-high reset (kb read register, neuron
//                registers, psum_out); weight stores are never cleared
//   kb_address   kernel buffer read/write address
//   kb_io        {we, bcast, lane[DEPTH-1:0], data[W-1:0]} host load port
//   dist_ctrl    {zcnt[DEPTH-1:0], rot[DEPTH-1:0]}
//   neuron_in    column j word = [W*(j+1)-1 -: W]
//   psum_in      row i chain seed = [W*(i+1)-1 -: W]
//   col_ctrl     column j = [8*(j+1)-1 -: 8]: {rsvd[3:0], zero, mac_en, kwrite, nload}
//   row_ctrl     bit i enables kernel writes into row i
//   common_ctrl  {shift[3*DEPTH-1:0], raddr[AL-1:0], waddr[AL-1:0], out_en}
//   psum_out     row i result = [W*(i+1)-1 -: W]
// -----------------------------------------------------------------------------
module conv_kernel_array #(
    parameter int DEPTH = 2,
    parameter int W     = 16,
    parameter int AB    = 11,
    parameter int AL    = 7
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [AB-1:0]           kb_address,
    input  logic [W+DEPTH+1:0]      kb_io,
    input  logic [2*DEPTH-1:0]      dist_ctrl,
    input  logic [W*(1<<DEPTH)-1:0] neuron_in,
    input  logic [W*(1<<DEPTH)-1:0] psum_in,
    input  logic [8*(1<<DEPTH)-1:0] col_ctrl,
    input  logic [(1<<DEPTH)-1:0]   row_ctrl,
    input  logic [3*DEPTH+2*AL:0]   common_ctrl,
    output logic [W*(1<<DEPTH)-1:0] psum_out
);
    localparam int D  = 1 << DEPTH;
    localparam int SW = 3 * DEPTH;
    localparam logic [SW-1:0] MAX_SHIFT = SW'(W - 1);

    // Field decode
    logic                kbWe;
    logic                kbBcast;
    logic [DEPTH-1:0]    kbLane;
    logic signed [W-1:0] kbData;
    logic [DEPTH-1:0]    distZcnt;
    logic [DEPTH-1:0]    distRot;
    logic [SW-1:0]       shiftAmt;
    logic [AL-1:0]       ksRaddr;
    logic [AL-1:0]       ksWaddr;
    logic                outEn;

    assign {kbWe, kbBcast, kbLane, kbData} = kb_io;
    assign {distZcnt, distRot}             = dist_ctrl;
    assign {shiftAmt, ksRaddr, ksWaddr, outEn} = common_ctrl;

    logic [D-1:0] colNload;
    logic [D-1:0] colKwrite;
    logic [D-1:0] colMacEn;
    logic [D-1:0] colZero;
    logic         unusedResv;

    always_comb begin
        colNload   = '0;
        colKwrite  = '0;
        colMacEn   = '0;
        colZero    = '0;
        unusedResv = 1'b0;
        for (int j = 0; j < D; j++) begin
            colNload[j]  = col_ctrl[8*j];
            colKwrite[j] = col_ctrl[8*j+1];
            colMacEn[j]  = col_ctrl[8*j+2];
            colZero[j]   = col_ctrl[8*j+3];
            unusedResv   = unusedResv ^ (^col_ctrl[8*j+4 +: 4]);
        end
    end

    // Product scaling: full 2W-bit product, arithmetic shift clamped to W-1,
    // then truncated (or clamped) back to W bits.
    function automatic logic signed [W-1:0] scaleProd(
        input logic signed [W-1:0] kern,
        input logic signed [W-1:0] neur,
        input logic [SW-1:0]       sh
    );
        logic signed [2*W-1:0] full;
        logic [SW-1:0]         shClamp;
        shClamp = (sh > MAX_SHIFT) ? MAX_SHIFT : sh;
        full    = (2*W)'(kern) * (2*W)'(neur);
`ifdef CONV_SATURATE_EN
        full = full >>> shClamp;
        // Fits in W bits only if the top W+1 bits are all copies of the sign.
        if (full[2*W-1:W-1] != {(W+1){full[2*W-1]}})
            return full[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return full[W-1:0];
`else
        return W'(full >>> shClamp);
`endif
    endfunction

    function automatic logic signed [W-1:0] addChain(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
`ifdef CONV_SATURATE_EN
        logic signed [W:0] s;
        s = (W+1)'(a) + (W+1)'(b);
        if (s[W] != s[W-1])
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return s[W-1:0];
`else
        return a + b;
`endif
    endfunction

    // Kernel buffer banks: one W-bit bank per lane, read-before-write.
    logic [D*W-1:0] kbRdWord;
    logic [D*W-1:0] kbQ_p1;

    for (genvar gl = 0; gl < D; gl++) begin : gBank
        logic [W-1:0] kbBank [2**AB];
        always_ff @(posedge CLK) begin
            if (!RST && kbWe && (kbBcast || (kbLane == DEPTH'(gl))))
                kbBank[kb_address] <= kbData;
        end
        assign kbRdWord[W*gl +: W] = kbBank[kb_address];
    end

    // ---- stage p1: registered buffer read word ----
    always_ff @(posedge CLK) begin
        if (RST)
            kbQ_p1 <= '0;
        else
            kbQ_p1 <= kbRdWord;
    end

    // Distributor: rotate lanes down by rot, then zero the top zcnt lanes.
    logic signed [W-1:0] distLane [D];
    logic [DEPTH-1:0]    srcIdx;

    always_comb begin
        srcIdx = '0;
        for (int i = 0; i < D; i++) begin
            distLane[i] = '0;
            srcIdx      = DEPTH'(i) + distRot;
            if (i < D - int'(distZcnt))
                distLane[i] = kbQ_p1[W*srcIdx +: W];
        end
    end

    // PE mesh: per-PE weight store (async read, so a same-cycle write is not
    // visible until the next cycle) and neuron register.
    logic signed [W-1:0] prod [D][D];

    for (genvar gi = 0; gi < D; gi++) begin : gRow
        for (genvar gj = 0; gj < D; gj++) begin : gCol
            logic signed [W-1:0] ksMem [2**AL];
            logic signed [W-1:0] nrReg;

            always_ff @(posedge CLK) begin
                if (!RST && colKwrite[gj] && row_ctrl[gi])
                    ksMem[ksWaddr] <= distLane[gi];
            end

            always_ff @(posedge CLK) begin
                if (RST)
                    nrReg <= '0;
                else if (colNload[gj])
                    nrReg <= neuron_in[W*gj +: W];
            end

            assign prod[gi][gj] = (colMacEn[gj] && !colZero[gj])
                                ? scaleProd(ksMem[ksRaddr], nrReg, shiftAmt) : '0;
        end
    end

    // Row chains ripple combinationally across every column.
    logic signed [W-1:0] acc;
    logic signed [W-1:0] rowSum [D];

    always_comb begin
        acc = '0;
        for (int i = 0; i < D; i++) begin
            acc = psum_in[W*i +: W];
            for (int j = 0; j < D; j++)
                acc = addChain(acc, prod[i][j]);
            rowSum[i] = acc;
        end
    end

    // ---- stage p1: registered row results ----
    always_ff @(posedge CLK) begin
        if (RST)
            psum_out <= '0;
        else if (outEn)
            for (int i = 0; i < D; i++)
                psum_out[W*i +: W] <= rowSum[i];
    end

endmodule

// File: tb/tb_conv_kernel_array.sv
// -----------------------------------------------------------------------------
// tb_conv_kernel_array
//   Directed bench for conv_kernel_array at D=4, W=16: buffer load and
//   distributor rotate/mask, single MAC, full row chains, shift/overflow
//   boundaries, output hold and mid-stream reset. Expected row vectors are
//   queued when stimulus is applied and compared when the output registers.
// -----------------------------------------------------------------------------
module tb_conv_kernel_array;
    localparam int DEPTH = 2;
    localparam int W     = 16;
    localparam int AB    = 11;
    localparam int AL    = 7;
    localparam int D     = 4;

`ifdef CONV_SATURATE_EN
    localparam logic [63:0] EXP_PROD0 = 64'h7FFF_7FFF_7FFF_7FFF;
    localparam logic [63:0] EXP_POS   = 64'h7FFF_7FFF_7FFF_7FFF;
    localparam logic [63:0] EXP_NEG   = 64'h8000_8000_8000_8000;
`else
    localparam logic [63:0] EXP_PROD0 = 64'h0000_0000_0000_0000;
    localparam logic [63:0] EXP_POS   = 64'h8003_8002_8001_8000;
    localparam logic [63:0] EXP_NEG   = 64'h7FFC_7FFD_7FFE_7FFF;
`endif

    logic                    CLK = 1'b0;
    logic                    RST;
    logic [AB-1:0]           kb_address;
    logic [W+DEPTH+1:0]      kb_io;
    logic [2*DEPTH-1:0]      dist_ctrl;
    logic [W*D-1:0]          neuron_in;
    logic [W*D-1:0]          psum_in;
    logic [8*D-1:0]          col_ctrl;
    logic [D-1:0]            row_ctrl;
    logic [3*DEPTH+2*AL:0]   common_ctrl;
    logic [W*D-1:0]          psum_out;

    // Field-level stimulus variables
    logic                weV, bcastV;
    logic [DEPTH-1:0]    laneV, zcntV, rotV;
    logic [W-1:0]        dataV;
    logic [D-1:0]        nloadV, kwrV, macV, zeroV, rowV;
    logic [3:0]          resvV;
    logic [5:0]          shiftV;
    logic [AL-1:0]       raddrV, waddrV;
    logic                outEnV;
    logic [W-1:0]        nIn [D];
    logic [W-1:0]        pIn [D];

    logic [63:0] expQ [$];
    int evaluated = 0;
    int failures  = 0;

    assign kb_io       = {weV, bcastV, laneV, dataV};
    assign dist_ctrl   = {zcntV, rotV};
    assign row_ctrl    = rowV;
    assign common_ctrl = {shiftV, raddrV, waddrV, outEnV};

    always_comb begin
        col_ctrl  = '0;
        neuron_in = '0;
        psum_in   = '0;
        for (int j = 0; j < D; j++) begin
            col_ctrl[8*j +: 8]   = {resvV, zeroV[j], macV[j], kwrV[j], nloadV[j]};
            neuron_in[W*j +: W]  = nIn[j];
            psum_in[W*j +: W]    = pIn[j];
        end
    end

    conv_kernel_array #(.DEPTH(DEPTH), .W(W), .AB(AB), .AL(AL)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .kb_address  (kb_address),
        .kb_io       (kb_io),
        .dist_ctrl   (dist_ctrl),
        .neuron_in   (neuron_in),
        .psum_in     (psum_in),
        .col_ctrl    (col_ctrl),
        .row_ctrl    (row_ctrl),
        .common_ctrl (common_ctrl),
        .psum_out    (psum_out)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Queue the expected row vector, let one edge pass, compare.
    task automatic check(input string tag, input logic [63:0] exp);
        logic [63:0] want;
        expQ.push_back(exp);
        tick();
        want = expQ.pop_front();
        evaluated++;
        assert (psum_out === want) else begin
            failures++;
            $error("FAIL %s: psum_out=%h expected %h", tag, psum_out, want);
        end
    endtask

    task automatic setP(input int a, input int b, input int c, input int d);
        pIn[0] = 16'(a); pIn[1] = 16'(b); pIn[2] = 16'(c); pIn[3] = 16'(d);
    endtask

    task automatic nload(input logic [3:0] mask, input int a, input int b, input int c, input int d);
        nIn[0] = 16'(a); nIn[1] = 16'(b); nIn[2] = 16'(c); nIn[3] = 16'(d);
        nloadV = mask;
        tick();
        nloadV = '0;
    endtask

    task automatic kbWrite(input int addr, input logic bc, input int lane, input int data);
        kb_address = AB'(addr);
        weV = 1'b1; bcastV = bc; laneV = DEPTH'(lane); dataV = 16'(data);
        tick();
        weV = 1'b0; bcastV = 1'b0;
    endtask

    // Read buffer word at addr, then push it through the distributor into ks[waddr].
    task automatic loadKs(input int addr, input int rot, input int zc,
                          input logic [3:0] cols, input logic [3:0] rows, input int wa);
        kb_address = AB'(addr);
        tick();
        rotV = DEPTH'(rot); zcntV = DEPTH'(zc);
        kwrV = cols; rowV = rows; waddrV = AL'(wa);
        tick();
        kwrV = '0; rowV = '0; rotV = '0; zcntV = '0;
    endtask

    task automatic macCheck(input string tag, input logic [3:0] mac, input int ra,
                            input int sh, input logic [63:0] exp);
        macV = mac; raddrV = AL'(ra); shiftV = 6'(sh); outEnV = 1'b1;
        check(tag, exp);
        macV = '0; outEnV = 1'b0; shiftV = '0;
    endtask

    initial begin
        RST = 1'b1; kb_address = '0;
        weV = 0; bcastV = 0; laneV = '0; dataV = '0; zcntV = '0; rotV = '0;
        nloadV = '0; kwrV = '0; macV = '0; zeroV = '0; rowV = '0; resvV = '0;
        shiftV = '0; raddrV = '0; waddrV = '0; outEnV = 1'b0;
        setP(0, 0, 0, 0);
        for (int j = 0; j < D; j++) nIn[j] = '0;
        tick();
        tick();

        // Reset dominates an enabled output load
        outEnV = 1'b1; setP(1, 2, 3, 4);
        check("reset_state", 64'h0);
        RST = 1'b0; outEnV = 1'b0; setP(0, 0, 0, 0);

        // Buffer load, then observe the distributor through column 0 with nr=1
        kbWrite(5, 1'b0, 0, 1);
        kbWrite(5, 1'b0, 1, 2);
        kbWrite(5, 1'b0, 2, 3);
        kbWrite(5, 1'b0, 3, 4);
        kbWrite(7, 1'b1, 0, 16'h00AA);
        nload(4'b0001, 1, 0, 0, 0);
        loadKs(5, 0, 0, 4'b0001, 4'hF, 1);
        macCheck("kb_rot0", 4'b0001, 1, 0, pk(1, 2, 3, 4));
        loadKs(5, 1, 0, 4'b0001, 4'hF, 2);
        macCheck("kb_rot1", 4'b0001, 2, 0, pk(2, 3, 4, 1));
        loadKs(5, 0, 2, 4'b0001, 4'hF, 3);
        macCheck("kb_zcnt2", 4'b0001, 3, 0, pk(1, 2, 0, 0));
        loadKs(5, 3, 1, 4'b0001, 4'hF, 4);
        macCheck("kb_rot3_zcnt1", 4'b0001, 4, 0, pk(4, 1, 2, 0));
        loadKs(7, 0, 0, 4'b0001, 4'hF, 8);
        macCheck("kb_bcast", 4'b0001, 8, 0, pk(16'hAA, 16'hAA, 16'hAA, 16'hAA));

        // Single MAC: 3*5 + seed
        kbWrite(9, 1'b1, 0, 3);
        loadKs(9, 0, 0, 4'b0001, 4'hF, 0);
        nload(4'b0001, 5, 0, 0, 0);
        setP(10, 0, 0, 0);
        macCheck("single_mac", 4'b0001, 0, 0, pk(25, 15, 15, 15));

        // Full row chains with ks=2 everywhere, neurons {1,2,3,4}
        kbWrite(10, 1'b1, 0, 2);
        loadKs(10, 0, 0, 4'hF, 4'hF, 5);
        nload(4'hF, 1, 2, 3, 4);
        setP(0, 0, 0, 0);
        resvV = 4'hF;
        macCheck("chain_all", 4'hF, 5, 0, pk(20, 20, 20, 20));
        resvV = 4'h0;
        setP(100, 200, 300, 400);
        macCheck("chain_seed", 4'hF, 5, 0, pk(120, 220, 320, 420));
        setP(0, 0, 0, 0);
        zeroV = 4'b0100;
        macCheck("chain_zero", 4'hF, 5, 0, pk(14, 14, 14, 14));
        zeroV = '0;

        // Write row 1 only while reading the same address: old value first
        kbWrite(12, 1'b1, 0, 7);
        tick();
        kwrV = 4'hF; rowV = 4'b0010; waddrV = 5;
        macV = 4'hF; raddrV = 5; outEnV = 1'b1;
        check("ks_rdw_old", pk(20, 20, 20, 20));
        kwrV = '0; rowV = '0;
        check("row_mask", pk(20, 70, 20, 20));
        macV = '0; outEnV = 1'b0;

        // Shift handling on 0x4000 * 0x4000
        kbWrite(11, 1'b1, 0, 16'h4000);
        loadKs(11, 0, 0, 4'b0001, 4'hF, 6);
        nload(4'b0001, 16'h4000, 0, 0, 0);
        macCheck("shift14", 4'b0001, 6, 14, {4{16'h4000}});
        macCheck("shift_clamp", 4'b0001, 6, 40, {4{16'h2000}});
        macCheck("prod_over", 4'b0001, 6, 0, EXP_PROD0);

        // Chain overflow at both ends (ks col0 @1 = {1,2,3,4})
        nload(4'b0001, 1, 0, 0, 0);
        setP(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        macCheck("chain_pos_ovf", 4'b0001, 1, 0, EXP_POS);
        nload(4'b0001, 16'hFFFF, 0, 0, 0);
        setP(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        macCheck("chain_neg_ovf", 4'b0001, 1, 0, EXP_NEG);

        // out_en low holds the registered result
        macV = 4'hF; raddrV = 5;
        setP(16'h1234, 1, 2, 3);
        check("hold1", EXP_NEG);
        setP(7, 16'h5555, 9, 16'hAAAA);
        check("hold2", EXP_NEG);
        macV = '0;

        // Mid-stream reset: clears output and neuron registers, keeps weights
        macV = 4'hF; raddrV = 5; outEnV = 1'b1; setP(1, 1, 1, 1);
        nIn[0] = 9; nIn[1] = 9; nIn[2] = 9; nIn[3] = 9; nloadV = 4'hF;
        RST = 1'b1;
        check("rst_out", 64'h0);
        RST = 1'b0; nloadV = '0; macV = '0; outEnV = 1'b0;
        setP(0, 0, 0, 0);
        macCheck("rst_nr_zero", 4'hF, 5, 0, 64'h0);
        nload(4'hF, 1, 2, 3, 4);
        macCheck("ks_kept", 4'hF, 5, 0, pk(20, 70, 20, 20));

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
